// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, ALU ops,
// register-file write-data selects and the FSM state type.
package mc_control_unit_pkg;

   localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
   localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
   localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
   localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
   localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
   localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
   localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
   localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
   localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [2:0] FUNC3_SR = 3'b101;

   localparam logic [2:0] RFWD_ALU    = 3'd0;
   localparam logic [2:0] RFWD_MEM    = 3'd1;
   localparam logic [2:0] RFWD_IMM    = 3'd2;
   localparam logic [2:0] RFWD_PC_IMM = 3'd3;
   localparam logic [2:0] RFWD_PC_4   = 3'd4;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      R_EXE  = 4'd2,
      I_EXE  = 4'd3,
      L_EXE  = 4'd4,
      L_MEM  = 4'd5,
      L_WB   = 4'd6,
      S_EXE  = 4'd7,
      S_MEM  = 4'd8,
      B_EXE  = 4'd9,
      LU_EXE = 4'd10,
      AU_EXE = 4'd11,
      J_EXE  = 4'd12,
      JL_EXE = 4'd13,
      TRAP   = 4'd14
   } state_t;

   // ALU op is {func7[5], func3}; only shifts-right use func7[5] for I-type
   function automatic logic [3:0] alu_op(input logic i_func7_b5, input logic [2:0] i_func3);
      return {i_func7_b5, i_func3};
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Data-bus handshake between the control unit (master) and the interconnect.
interface mc_control_unit_if;

   logic bus_req;
   logic bus_we;
   logic bus_ready;

   modport master (
      output bus_req,
      output bus_we,
      input  bus_ready
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      output bus_ready
   );

endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational ALU-op decode from opcode/func3/func7[5]; anything that is not
// R, I or B type computes an address or sum and gets ADD.
module mc_alu_decoder
   import mc_control_unit_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_func3,
   input  logic       i_func7_b5,
   output logic [3:0] o_alu_control
);

   always_comb begin
      o_alu_control = ALU_ADD;
      case (i_opcode)
         OP_TYPE_R: o_alu_control = alu_op(i_func7_b5, i_func3);
         // instr[30] is part of the immediate for all I-type ops except SRLI/SRAI
         OP_TYPE_I: o_alu_control = alu_op((i_func3 == FUNC3_SR) ? i_func7_b5 : 1'b0, i_func3);
         OP_TYPE_B: o_alu_control = alu_op(1'b0, i_func3);
         default:   o_alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I main control FSM with load/store bus handshake.
// Optional macro ILLEGAL_INSTR_TRAP_EN: unknown opcodes enter a sticky TRAP state.
module mc_control_unit
   import mc_control_unit_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               i_instr_code,
   output logic                      o_pc_en,
   output logic                      o_reg_file_we,
   output logic [3:0]                o_alu_control,
   output logic                      o_alu_src_mux_sel,
   output logic [2:0]                o_rfwd_src_mux_sel,
   output logic                      o_branch,
   output logic                      o_jal,
   output logic                      o_jalr,
   mc_control_unit_if.master         io_bus,
   output logic                      o_illegal_instr
);

   state_t     r_state;
   state_t     w_next_state;
   logic [6:0] w_opcode;
   logic [3:0] w_alu_dec;
   logic       w_bus_req;
   logic       w_bus_we;
   logic       w_illegal;
   logic       w_unused_instr_bits;

   assign w_opcode = i_instr_code[6:0];
   assign w_unused_instr_bits = ^{i_instr_code[31], i_instr_code[29:15], i_instr_code[11:7]};

   mc_alu_decoder u_alu_decoder (
      .i_opcode      (w_opcode),
      .i_func3       (i_instr_code[14:12]),
      .i_func7_b5    (i_instr_code[30]),
      .o_alu_control (w_alu_dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state       = r_state;
      o_pc_en            = 1'b0;
      o_reg_file_we      = 1'b0;
      o_alu_control      = ALU_ADD;
      o_alu_src_mux_sel  = 1'b0;
      o_rfwd_src_mux_sel = RFWD_ALU;
      o_branch           = 1'b0;
      o_jal              = 1'b0;
      o_jalr             = 1'b0;
      w_bus_req          = 1'b0;
      w_bus_we           = 1'b0;
      w_illegal          = 1'b0;

      case (r_state)
         FETCH: begin
            o_pc_en      = 1'b1;
            w_next_state = DECODE;
         end
         DECODE: begin
            case (w_opcode)
               OP_TYPE_R:  w_next_state = R_EXE;
               OP_TYPE_I:  w_next_state = I_EXE;
               OP_TYPE_L:  w_next_state = L_EXE;
               OP_TYPE_S:  w_next_state = S_EXE;
               OP_TYPE_B:  w_next_state = B_EXE;
               OP_TYPE_LU: w_next_state = LU_EXE;
               OP_TYPE_AU: w_next_state = AU_EXE;
               OP_TYPE_J:  w_next_state = J_EXE;
               OP_TYPE_JL: w_next_state = JL_EXE;
`ifdef ILLEGAL_INSTR_TRAP_EN
               default:    w_next_state = TRAP;
`else
               default:    w_next_state = FETCH;
`endif
            endcase
         end
         R_EXE: begin
            o_alu_control = w_alu_dec;
            o_reg_file_we = 1'b1;
            w_next_state  = FETCH;
         end
         I_EXE: begin
            o_alu_control     = w_alu_dec;
            o_alu_src_mux_sel = 1'b1;
            o_reg_file_we     = 1'b1;
            w_next_state      = FETCH;
         end
         LU_EXE: begin
            o_reg_file_we      = 1'b1;
            o_rfwd_src_mux_sel = RFWD_IMM;
            w_next_state       = FETCH;
         end
         AU_EXE: begin
            o_reg_file_we      = 1'b1;
            o_rfwd_src_mux_sel = RFWD_PC_IMM;
            w_next_state       = FETCH;
         end
         B_EXE: begin
            o_alu_control = w_alu_dec;
            o_branch      = 1'b1;
            w_next_state  = FETCH;
         end
         J_EXE: begin
            o_jal              = 1'b1;
            o_reg_file_we      = 1'b1;
            o_rfwd_src_mux_sel = RFWD_PC_4;
            w_next_state       = FETCH;
         end
         JL_EXE: begin
            o_jal              = 1'b1;
            o_jalr             = 1'b1;
            o_reg_file_we      = 1'b1;
            o_rfwd_src_mux_sel = RFWD_PC_4;
            w_next_state       = FETCH;
         end
         S_EXE: begin
            o_alu_src_mux_sel = 1'b1;
            w_next_state      = S_MEM;
         end
         S_MEM: begin
            o_alu_src_mux_sel = 1'b1;
            w_bus_req         = 1'b1;
            w_bus_we          = 1'b1;
            if (io_bus.bus_ready) w_next_state = FETCH;
         end
         L_EXE: begin
            o_alu_src_mux_sel = 1'b1;
            w_next_state      = L_MEM;
         end
         L_MEM: begin
            o_alu_src_mux_sel = 1'b1;
            w_bus_req         = 1'b1;
            if (io_bus.bus_ready) w_next_state = L_WB;
         end
         L_WB: begin
            o_alu_src_mux_sel  = 1'b1;
            o_reg_file_we      = 1'b1;
            o_rfwd_src_mux_sel = RFWD_MEM;
            w_next_state       = FETCH;
         end
`ifdef ILLEGAL_INSTR_TRAP_EN
         TRAP: begin
            w_illegal    = 1'b1;
            w_next_state = TRAP;
         end
`endif
         default: w_next_state = FETCH;
      endcase

      // Reset forces every output low at once, even though the state is FETCH
      if (reset) begin
         o_pc_en            = 1'b0;
         o_reg_file_we      = 1'b0;
         o_alu_control      = ALU_ADD;
         o_alu_src_mux_sel  = 1'b0;
         o_rfwd_src_mux_sel = RFWD_ALU;
         o_branch           = 1'b0;
         o_jal              = 1'b0;
         o_jalr             = 1'b0;
         w_bus_req          = 1'b0;
         w_bus_we           = 1'b0;
         w_illegal          = 1'b0;
      end
   end

   assign io_bus.bus_req  = w_bus_req;
   assign io_bus.bus_we   = w_bus_we;
   assign o_illegal_instr = w_illegal;

endmodule
